// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter: picks one enabled requesting channel, runs the HRQ/HLDA hold handshake
// and drives one-hot DACK until TC. Define DMA_ROTATE_PRIORITY_EN to enable rotating priority.
module dma_priority_arbiter #(
   parameter int NUM_CH           = 4,
   parameter bit DREQ_ACTIVE_HIGH = 1'b1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [NUM_CH-1:0] dreq,
   input  logic [NUM_CH-1:0] masked_channels,
   input  logic              hlda,
   input  logic              tc,
   input  logic              rotate_mode,
   output logic              hrq,
   output logic [NUM_CH-1:0] dack,
   output logic [1:0]        active_ch,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      HOLD_REQ,
      SERVICE,
      RELEASE
   } state_t;

   state_t             state;
   logic [NUM_CH-1:0]  dreq_norm;
   logic [NUM_CH-1:0]  eff;
   logic [1:0]         base;
   logic [1:0]         winner;
   logic               active_req;
   logic               service_done;

   assign dreq_norm    = DREQ_ACTIVE_HIGH ? dreq : ~dreq;
   assign eff          = dreq_norm & ~masked_channels;
   assign active_req   = eff[active_ch];
   assign service_done = (state == SERVICE) && hlda && (tc || !active_req);

   // Scan from lowest priority up so the highest-priority requester is written last.
   always_comb begin
      logic [1:0] idx;
      winner = base;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = base + 2'(3 - k);
         if (eff[idx]) winner = idx;
      end
   end

`ifdef DMA_ROTATE_PRIORITY_EN
   logic [1:0] ptr;
   logic       rot_q;

   assign base = rotate_mode ? ptr : '0;

   // rotate_mode is captured while idle; it decides whether the finishing service rotates.
   always_ff @(posedge CLK) begin
      if (reset) begin
         ptr   <= '0;
         rot_q <= 1'b0;
      end else if (state == IDLE) begin
         rot_q <= rotate_mode;
         if (!rotate_mode) ptr <= '0;
      end else if (service_done && rot_q) begin
         ptr <= active_ch + 2'd1;
      end
   end
`else
   logic unused_rotate_mode;

   assign base               = '0;
   assign unused_rotate_mode = rotate_mode;
`endif

   always_ff @(posedge CLK) begin
      if (reset) begin
         state     <= IDLE;
         hrq       <= 1'b0;
         dack      <= '0;
         active_ch <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (eff != '0) begin
                  active_ch <= winner;
                  hrq       <= 1'b1;
                  busy      <= 1'b1;
                  state     <= HOLD_REQ;
               end
            end
            HOLD_REQ: begin
               if (!active_req) begin
                  hrq   <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (hlda) begin
                  dack  <= NUM_CH'(1) << active_ch;
                  state <= SERVICE;
               end
            end
            SERVICE: begin
               if (!hlda) begin
                  dack  <= '0;
                  hrq   <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (service_done) begin
                  dack  <= '0;
                  hrq   <= 1'b0;
                  busy  <= 1'b0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               if (!hlda) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Arbitration stage directly downstream of the DMA channel mask register.
- Combines the 4-bit masked-channel vector with per-channel DREQ lines and selects one channel by fixed or rotating priority.
- Runs the HRQ/HLDA bus-hold handshake with the CPU and drives one-hot DACK to the winning channel until the transfer ends.
- Its grant output feeds the address/count transfer engine.

Parameters:
- NUM_CH, 4, number of channels; only 4 is supported.
- DREQ_ACTIVE_HIGH, 1: 1 means dreq bits are active-high; 0 means they are inverted at input.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- dreq  input  4  per-channel DMA request, polarity per DREQ_ACTIVE_HIGH.
- masked_channels  input  4  from mask register; 1 = channel disabled, 0 = enabled.
- hlda  input  1  hold acknowledge from CPU.
- tc  input  1  terminal count pulse from transfer engine for the active channel.
- rotate_mode  input  1  command-register priority bit: 0 = fixed, 1 = rotating.
- hrq  output  1  hold request to CPU.
- dack  output  4  one-hot channel acknowledge, active-high.
- active_ch  output  2  index of granted channel; valid while busy = 1.
- busy  output  1  high in HOLD_REQ and SERVICE.

Behaviour:
- Effective request: eff = dreq_norm & ~masked_channels, evaluated every cycle.
- Reset:
  - Synchronous reset overrides everything, including mid-operation.
  - Forces state = IDLE, hrq = 0, dack = 0000, active_ch = 0, busy = 0, priority pointer = 0 (ch0 highest).
- States: IDLE, HOLD_REQ, SERVICE, RELEASE.
- IDLE:
  - If eff != 0, latch the winner into active_ch.
  - Assert hrq and busy on the same edge; next state HOLD_REQ.
  - Latency: eff sampled at edge N gives hrq = 1 after edge N.
- HOLD_REQ:
  - hrq held at 1.
  - If hlda = 1 and eff[active_ch] = 1: dack[active_ch] = 1, go SERVICE.
  - If eff[active_ch] drops (dreq removed or channel masked) before hlda: hrq = 0, busy = 0, go IDLE, no rotation. Takes priority over hlda in the same cycle.
  - No timeout; the arbiter waits for hlda indefinitely.
- SERVICE:
  - hrq = 1, dack one-hot on active_ch, busy = 1.
  - Exits, in priority order:
    - hlda = 0: abort. dack = 0, hrq = 0, go IDLE, no rotation.
    - tc = 1, or eff[active_ch] = 0 (including newly masked): dack = 0, hrq = 0, go RELEASE, rotation applied.
  - Requests on other channels are ignored while in SERVICE; there is no preemption.
- RELEASE:
  - busy = 0, hrq = 0.
  - Wait for hlda = 0, then go IDLE.
  - A new request cannot raise hrq until the cycle after IDLE is re-entered.
- Priority:
  - Fixed: ch0 > ch1 > ch2 > ch3.
  - Rotating: after a completed service of ch n, pointer = (n+1) mod 4 becomes highest; order wraps around (3 → 0).
- rotate_mode is sampled only in IDLE.
  - Changing rotate_mode from 1 to 0 resets the pointer to 0 at the next IDLE arbitration.

Optional Feature:
- Macro: DMA_ROTATE_PRIORITY_EN.
- Defined: rotating priority implemented as described; rotate_mode honored.
- Undefined:
  - rotate_mode is ignored and the pointer logic is not synthesized.
  - Priority is always fixed ch0 > ch1 > ch2 > ch3.
  - All other behaviour is identical.

Test Plan:
- Reset mid-SERVICE: with dack = 0100, assert reset for 1 cycle → next edge hrq = 0, dack = 0000, busy = 0, state IDLE.
- Fixed priority, masked_channels = 0001, dreq = 1011 → hrq = 1 after 1 edge; hlda = 1 → dack = 0010, active_ch = 1.
- Service end by tc: in SERVICE on ch2, pulse tc = 1 → dack = 0000 and hrq = 0 next edge; hlda held 1 keeps state RELEASE; hlda = 0 → IDLE.
- Rotating (macro defined, rotate_mode = 1), dreq = 1111 constantly, hlda following hrq, tc after each grant → grant order ch0, ch1, ch2, ch3, ch0.
- Mask during wait: HOLD_REQ on ch3 and hlda = 0; masked_channels set to 1000 → hrq drops next edge, busy = 0, and a pending ch1 request is granted after re-arbitration.
- Abort: in SERVICE on ch0, hlda = 0 and tc = 1 in the same cycle → IDLE without rotation; the next grant with dreq = 1111 is ch0.
